// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the three-way bus arbiter and its requesters
package arb_pkg;
    typedef enum logic [1:0] {IDLE, REQ, ACCESS, RELEASE} arb_req_state_t;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_TMO_W = 8;
    localparam logic [1:0] PROC_A = 2'd0;
    localparam logic [1:0] PROC_B = 2'd1;
    localparam logic [1:0] PROC_C = 2'd2;
endpackage

// File: rtl/arb_down_counter.sv
// arb_down_counter: loadable, enable-gated down counter that holds at zero
module arb_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/arb_requester.sv
// arb_requester: processor-side req/gnt initiator that runs one multi-beat bus job at a time
module arb_requester
    import arb_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int TMO_W = DEF_TMO_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [TMO_W-1:0] tmo_limit,
    input  logic             gnt,
    output logic             req,
    output logic             bus_en,
    output logic             busy,
    output logic [LEN_W-1:0] beats_left,
    output logic             done,
    output logic             timeout,
    output logic             preempted
);
    arb_req_state_t state_q, state_d;
    logic [TMO_W-1:0] wait_q, wait_d;
    logic req_q, bus_en_q, busy_q, done_q, timeout_q, preempted_q;
    logic in_idle, in_req, in_acc, tmo_hit, last_beat;
    assign in_idle   = state_q == IDLE;
    assign in_req    = state_q == REQ;
    assign in_acc    = state_q == ACCESS;
    assign tmo_hit   = tmo_limit != '0 && wait_q == tmo_limit - TMO_W'(1);
    assign last_beat = in_acc && gnt && beats_left == LEN_W'(1);
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (gnt) state_d = ACCESS; else if (tmo_hit) state_d = RELEASE;
            ACCESS:  if (!gnt) state_d = REQ; else if (beats_left == LEN_W'(1)) state_d = RELEASE;
            default: state_d = IDLE;
        endcase
    end
    // saturating wait counter, cleared whenever we are not actively waiting
    always_comb wait_d = (in_req && !gnt) ? (wait_q == '1 ? wait_q : wait_q + TMO_W'(1)) : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            req_q       <= 1'b0;
            bus_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            preempted_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            req_q       <= state_d == REQ || state_d == ACCESS;
            bus_en_q    <= state_d == ACCESS;
            busy_q      <= state_d != IDLE;
            done_q      <= last_beat;
            timeout_q   <= in_req && !gnt && tmo_hit;
            preempted_q <= in_acc && !gnt;
        end
    end
    arb_down_counter #(.W(LEN_W)) u_beats (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (in_idle && start),
        .load_val_i(len == '0 ? LEN_W'(1) : len),
        .en_i      (in_acc && gnt),
        .cnt_o     (beats_left)
    );
    assign req       = req_q;
    assign bus_en    = bus_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign preempted = preempted_q;
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: randomized and directed jobs checked cycle-by-cycle against a job-level model
module tb_arb_requester;
    localparam int LW = 4;
    localparam int TW = 8;
    localparam int MAXC = 256;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, gnt = 1'b0;
    logic [LW-1:0] len = '0;
    logic [TW-1:0] tmo_limit = '0;
    logic req, bus_en, busy, done, timeout, preempted;
    logic [LW-1:0] beats_left;
    int checks = 0, failures = 0;
    logic gnt_arr[MAXC];
    logic [9:0] exp_v[MAXC];
    int n_bus, n_beat, n_done, n_tmo, n_pre, done_cyc, tmo_cyc, pre_beats, last;

    arb_requester #(.LEN_W(LW), .TMO_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .tmo_limit(tmo_limit), .gnt(gnt),
        .req(req), .bus_en(bus_en), .busy(busy), .beats_left(beats_left),
        .done(done), .timeout(timeout), .preempted(preempted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] pk(bit r, bit b, bit y, bit d, bit t, bit p, int bl);
        return {r, b, y, d, t, p, 4'(bl)};
    endfunction

    function automatic logic [9:0] obs();
        return {req, bus_en, busy, done, timeout, preempted, beats_left};
    endfunction

    // cycle c follows edge c-1; gnt_arr[c] is the grant sampled at edge c
    task automatic model(input int eff, input int tmo, output int lst);
        int c = 1, w, rem = eff;
        bit fin = 0, pf = 0;
        while (!fin) begin
            w = 0;
            while (1) begin
                exp_v[c] = pk(1, 0, 1, 0, 0, pf, rem);
                pf = 0;
                if (gnt_arr[c]) begin c++; break; end
                if (tmo != 0 && w == tmo - 1) begin
                    c++;
                    exp_v[c] = pk(0, 0, 1, 0, 1, 0, rem);
                    fin = 1;
                    break;
                end
                w++;
                c++;
            end
            if (fin) break;
            while (1) begin
                exp_v[c] = pk(1, 1, 1, 0, 0, 0, rem);
                if (!gnt_arr[c]) begin c++; pf = 1; break; end
                rem--;
                c++;
                if (rem == 0) begin
                    exp_v[c] = pk(0, 0, 1, 1, 0, 0, 0);
                    fin = 1;
                    break;
                end
            end
        end
        lst = c;
        for (int i = c + 1; i < MAXC; i++) exp_v[i] = pk(0, 0, 0, 0, 0, 0, rem);
    endtask

    // call just after a clock edge with the DUT idle; a start pulse during RELEASE must be ignored
    task automatic run_job(input int l, input int tmo);
        model(l == 0 ? 1 : l, tmo, last);
        {n_bus, n_beat, n_done, n_tmo, n_pre, done_cyc, tmo_cyc, pre_beats} = '0;
        start = 1'b1;
        len = LW'(l);
        tmo_limit = TW'(tmo);
        gnt = gnt_arr[0];
        for (int c = 1; c <= last + 2; c++) begin
            @(posedge clk);
            #1;
            start = (c == last) || (c < last && $urandom_range(0, 3) == 0);
            len = LW'($urandom);
            gnt = gnt_arr[c];
            chk($sformatf("cyc%0d", c), 32'(obs()), 32'(exp_v[c]));
            n_bus += int'(bus_en);
            n_beat += int'(bus_en && gnt);
            n_done += int'(done);
            n_tmo += int'(timeout);
            n_pre += int'(preempted);
            if (done) done_cyc = c;
            if (timeout) tmo_cyc = c;
            if (preempted) pre_beats = int'(beats_left);
        end
        start = 1'b0;
    endtask

    task automatic fill_gnt(input int from_hi, input int lo_a, input int lo_b);
        for (int i = 0; i < MAXC; i++) gnt_arr[i] = i >= from_hi && !(i >= lo_a && i <= lo_b);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 32'(obs()), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_gnt(0, -1, -1);
        run_job(3, 0);
        chk("a_done_cyc", done_cyc, 5);
        chk("a_bus", n_bus, 3);
        run_job(0, 0);
        chk("len0_bus", n_bus, 1);
        chk("len0_done", n_done, 1);
        fill_gnt(MAXC, -1, -1);
        run_job(3, 4);
        chk("tmo_cyc", tmo_cyc, 5);
        chk("tmo_bus", n_bus, 0);
        chk("tmo_done", n_done, 0);
        fill_gnt(0, 4, 5);
        run_job(6, 0);
        chk("pre_cnt", n_pre, 1);
        chk("pre_beats", pre_beats, 4);
        chk("pre_total_beats", n_beat, 6);
        chk("pre_done", n_done, 1);
        fill_gnt(0, 4, MAXC);
        run_job(2, 0);
        chk("last_done", n_done, 1);
        chk("last_pre", n_pre, 0);
        // asynchronous reset in the middle of the third beat
        fill_gnt(0, -1, -1);
        start = 1'b1;
        len = 4'd5;
        tmo_limit = '0;
        gnt = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_bl", 32'(beats_left), 3);
        chk("mid_bus", 32'(bus_en), 1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 32'(obs()), 0);
        @(posedge clk);
        #1;
        chk("rst_hold", 32'(obs()), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_job(2, 0);
        chk("after_rst_done", n_done, 1);
        chk("after_rst_bus", n_bus, 2);
        for (int j = 0; j < 40; j++) begin
            int p;
            p = $urandom_range(3, 9);
            for (int i = 0; i < MAXC; i++) gnt_arr[i] = i >= 150 || $urandom_range(0, 9) < p;
            run_job($urandom_range(0, 15), $urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 20));
            chk("rnd_end", n_done + n_tmo, 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
